// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the programmable sequence detector family.
//   DEF_MAX_LEN / DEF_CNT_W : default pattern length and counter width
//   DEF_LEN_W               : width of a length field for DEF_MAX_LEN
//   clog2()                 : ceil(log2(n)), usable in constant expressions
//   seq_cfg_t               : configuration bundle {pat, len, overlap} at the
//                             default sizes, for blocks that pass a config
//                             around as one value
// -----------------------------------------------------------------------------
package seq_det_pkg;

   localparam int DEF_MAX_LEN = 8;
   localparam int DEF_CNT_W   = 8;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   localparam int DEF_LEN_W = clog2(DEF_MAX_LEN + 1);

   typedef struct packed {
      logic [DEF_MAX_LEN-1:0] pat;
      logic [DEF_LEN_W-1:0]   len;
      logic                   overlap;
   } seq_cfg_t;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// CNT_W-bit up counter that sticks at all-ones.
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   i_clear : synchronous clear (same effect as reset)
//   i_inc   : increment by one this cycle unless already saturated
//   o_value : current count
//   o_sat   : count is all-ones
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_value,
   output logic             o_sat
);

   logic [CNT_W-1:0] r_value;
   logic             w_sat;

   assign w_sat   = &r_value;
   assign o_value = r_value;
   assign o_sat   = w_sat;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear) begin
         r_value <= '0;
      end else if (i_inc && !w_sat) begin
         r_value <= r_value + CNT_W'(1);
      end
   end

endmodule

// File: rtl/param_seq_detector.sv
// -----------------------------------------------------------------------------
// param_seq_detector
// Run-time programmable Mealy sequence detector on a serial bit stream.
//   clk         : clock, rising edge
//   clr         : synchronous active-low reset (priority over everything)
//   cfg_load    : latch cfg_pat/cfg_len/cfg_overlap, clear history and count
//   cfg_pat     : pattern, bit [len-1] arrives first, bit [0] arrives last
//   cfg_len     : pattern length 0..MAX_LEN (larger values clamp to MAX_LEN)
//   cfg_overlap : 1 = matches may share bits, 0 = each match starts fresh
//   en          : w carries a valid bit this cycle
//   w           : serial input bit
//   out         : combinational match, high in the cycle of the last bit
//   match_cnt   : saturating number of matches since reset/load
//   cnt_sat     : match_cnt is all-ones
// -----------------------------------------------------------------------------
module param_seq_detector
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic                           clk,
   input  logic                           clr,
   input  logic                           cfg_load,
   input  logic [MAX_LEN-1:0]             cfg_pat,
   input  logic [clog2(MAX_LEN+1)-1:0]    cfg_len,
   input  logic                           cfg_overlap,
   input  logic                           en,
   input  logic                           w,
   output logic                           out,
   output logic [CNT_W-1:0]               match_cnt,
   output logic                           cnt_sat
);

   localparam int LEN_W  = clog2(MAX_LEN + 1);
   localparam int HIST_W = MAX_LEN - 1;

   typedef struct packed {
      logic [MAX_LEN-1:0] pat;
      logic [LEN_W-1:0]   len;
      logic               overlap;
   } cfg_t;

   cfg_t               r_cfg;
   logic [HIST_W-1:0]  r_hist;
   logic [LEN_W-1:0]   r_fill;

   logic [MAX_LEN-1:0] w_window;
   logic [MAX_LEN-1:0] w_mask;
   logic [LEN_W-1:0]   w_len_m1;
   logic [LEN_W-1:0]   w_len_clamped;
   logic               w_match;

   // The newest MAX_LEN bits including the one on w this cycle; the low
   // HIST_W bits are also exactly the next history value.
   assign w_window = {r_hist, w};

   // Only the low len bits of the window/pattern take part in the compare.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (i < int'(r_cfg.len)) w_mask[i] = 1'b1;
      end
   end

   assign w_len_m1      = r_cfg.len - LEN_W'(1);
   assign w_len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

   // For len 1, len-1 is 0 so the fill test always passes and the mask hides
   // the history; len 0 is excluded explicitly.
   assign w_match = clr && !cfg_load && en &&
                    (r_cfg.len != '0) &&
                    (r_fill >= w_len_m1) &&
                    (((w_window ^ r_cfg.pat) & w_mask) == '0);

   assign out = w_match;

   always_ff @(posedge clk) begin
      if (!clr) begin
         r_cfg.pat     <= '0;
         r_cfg.len     <= '0;
         r_cfg.overlap <= 1'b1;
         r_hist        <= '0;
         r_fill        <= '0;
      end else if (cfg_load) begin
         r_cfg.pat     <= cfg_pat;
         r_cfg.len     <= w_len_clamped;
         r_cfg.overlap <= cfg_overlap;
         r_hist        <= '0;
         r_fill        <= '0;
      end else if (en) begin
         r_hist <= w_window[HIST_W-1:0];
         // In non-overlap mode a match consumes its bits: history still
         // shifts, but they no longer count toward the next match.
         if (w_match && !r_cfg.overlap) begin
            r_fill <= '0;
         end else if (r_fill != LEN_W'(HIST_W)) begin
            r_fill <= r_fill + LEN_W'(1);
         end
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .i_clk   (clk),
      .i_rst_n (clr),
      .i_clear (cfg_load),
      .i_inc   (w_match),
      .o_value (match_cnt),
      .o_sat   (cnt_sat)
   );

endmodule

// File: tb/tb_param_seq_detector.sv
// -----------------------------------------------------------------------------
// tb_param_seq_detector
// Bench for param_seq_detector: u_dut (defaults) and u_dut2 (CNT_W=2) share
// all inputs. A behavioural model predicts `out` for every driven cycle into
// exp_q; the scoreboard pops and compares at the falling edge.
// -----------------------------------------------------------------------------
module tb_param_seq_detector;

   // ---------------- clock / reset / signals ----------------
   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       clr;
   logic       cfg_load;
   logic [7:0] cfg_pat;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       en;
   logic       w;
   logic       out1, out2;
   logic [7:0] cnt1;
   logic [1:0] cnt2;
   logic       sat1, sat2;

   param_seq_detector u_dut (
      .clk(clk), .clr(clr), .cfg_load(cfg_load), .cfg_pat(cfg_pat),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .en(en), .w(w),
      .out(out1), .match_cnt(cnt1), .cnt_sat(sat1)
   );

   param_seq_detector #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (
      .clk(clk), .clr(clr), .cfg_load(cfg_load), .cfg_pat(cfg_pat),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .en(en), .w(w),
      .out(out2), .match_cnt(cnt2), .cnt_sat(sat2)
   );

   int          checks   = 0;
   int          failures = 0;
   logic [0:0]  exp_q[$];
   logic [31:0] out_log;

   // plan stream, bit 16 is the first bit sent
   logic [16:0] stream = 17'b00110101001011100;

   // ---------------- reference model ----------------
   logic        m_bits[$];
   int          m_since;
   logic [7:0]  m_pat;
   int          m_len;
   logic        m_ovl;

   task automatic model_clear();
      m_bits.delete();
      m_since = 0;
   endtask

   task automatic model_bit(input logic b, output logic m);
      m_bits.push_back(b);
      m_since++;
      m = 1'b0;
      if (m_len > 0 && m_since >= m_len) begin
         m = 1'b1;
         for (int i = 0; i < m_len; i++)
            if (m_bits[m_bits.size() - 1 - i] !== m_pat[i]) m = 1'b0;
      end
      if (m && !m_ovl) m_since = 0;
   endtask

   // ---------------- scoreboard ----------------
   task automatic score_out();
      logic [0:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty: got out=%0b with no expectation", out1);
      end else begin
         e = exp_q.pop_front();
         if (out1 !== e[0]) begin
            failures++;
            $display("FAIL out: got %0b expected %0b at t=%0t", out1, e[0], $time);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_bit(input logic b);
      logic m;
      @(posedge clk); #1;
      cfg_load = 1'b0; en = 1'b1; w = b;
      model_bit(b, m);
      exp_q.push_back(m);
      @(negedge clk);
      out_log = {out_log[30:0], out1};
      score_out();
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
      cfg_load = 1'b0; en = 1'b0; w = 1'($urandom_range(0, 1));
      exp_q.push_back(1'b0);
      @(negedge clk);
      score_out();
   endtask

   task automatic do_load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
      @(posedge clk); #1;
      cfg_load = 1'b1; en = 1'b1; w = 1'b1;
      cfg_pat = pat; cfg_len = len; cfg_overlap = ovl;
      m_pat = pat; m_len = (len > 8) ? 8 : int'(len); m_ovl = ovl;
      model_clear();
      exp_q.push_back(1'b0);
      @(negedge clk);
      score_out();
   endtask

   task automatic do_reset(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         clr = 1'b0; cfg_load = 1'b0; en = 1'b1; w = 1'b1;
         exp_q.push_back(1'b0);
         @(negedge clk);
         score_out();
      end
      @(posedge clk); #1;
      clr = 1'b1; en = 1'b0;
      m_pat = '0; m_len = 0; m_ovl = 1'b1;
      model_clear();
   endtask

   task automatic settle();
      @(posedge clk); #1;
      en = 1'b0; cfg_load = 1'b0;
   endtask

   task automatic send_stream();
      out_log = '0;
      for (int i = 16; i >= 0; i--) drive_bit(stream[i]);
      settle();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset(2);
      checks++;
      if (cnt1 !== 8'd0 || sat1 !== 1'b0 || cnt2 !== 2'd0 || sat2 !== 1'b0) begin
         failures++;
         $display("FAIL reset_cnt: got cnt1=%0d sat1=%0b cnt2=%0d sat2=%0b expected all 0",
                  cnt1, sat1, cnt2, sat2);
      end
      out_log = '0;
      drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1);
      settle();
      checks++;
      if (out_log !== 32'd0 || cnt1 !== 8'd0) begin
         failures++;
         $display("FAIL reset_idle: got log=%0h cnt=%0d expected 0 0", out_log, cnt1);
      end
   endtask

   task automatic test_overlap();
      do_load(8'b101, 4'd3, 1'b1);
      send_stream();
      checks++;
      if (out_log[16:0] !== 17'b00000101000010000) begin
         failures++;
         $display("FAIL overlap_pos: got %b expected %b", out_log[16:0], 17'b00000101000010000);
      end
      checks++;
      if (cnt1 !== 8'd3) begin
         failures++;
         $display("FAIL overlap_cnt: got %0d expected 3", cnt1);
      end
   endtask

   task automatic test_non_overlap();
      do_load(8'b101, 4'd3, 1'b0);
      send_stream();
      checks++;
      if (out_log[16:0] !== 17'b00000100000010000) begin
         failures++;
         $display("FAIL nonovl_pos: got %b expected %b", out_log[16:0], 17'b00000100000010000);
      end
      checks++;
      if (cnt1 !== 8'd2) begin
         failures++;
         $display("FAIL nonovl_cnt: got %0d expected 2", cnt1);
      end
   endtask

   task automatic test_len4();
      do_load(8'b1011, 4'd4, 1'b1);
      send_stream();
      checks++;
      if (out_log[16:0] !== 17'b00000000000001000) begin
         failures++;
         $display("FAIL len4_pos: got %b expected %b", out_log[16:0], 17'b00000000000001000);
      end
      checks++;
      if (cnt1 !== 8'd1) begin
         failures++;
         $display("FAIL len4_cnt: got %0d expected 1", cnt1);
      end
   endtask

   task automatic test_gaps();
      do_load(8'b101, 4'd3, 1'b1);
      out_log = '0;
      for (int i = 16; i >= 0; i--) begin
         if ($urandom_range(0, 1) == 1) begin
            int g;
            g = int'($urandom_range(1, 3));
            for (int k = 0; k < g; k++) idle_cycle();
         end
         drive_bit(stream[i]);
      end
      idle_cycle();
      settle();
      checks++;
      if (out_log[16:0] !== 17'b00000101000010000) begin
         failures++;
         $display("FAIL gaps_pos: got %b expected %b", out_log[16:0], 17'b00000101000010000);
      end
      checks++;
      if (cnt1 !== 8'd3) begin
         failures++;
         $display("FAIL gaps_cnt: got %0d expected 3", cnt1);
      end
   endtask

   task automatic test_saturate();
      int exp_c[6] = '{1, 2, 3, 3, 3, 3};
      do_load(8'b1, 4'd1, 1'b1);
      for (int k = 0; k < 6; k++) begin
         drive_bit(1'b1);
         checks++;
         if (out2 !== 1'b1) begin
            failures++;
            $display("FAIL sat_out[%0d]: got %0b expected 1", k, out2);
         end
         settle();
         checks++;
         if (cnt2 !== 2'(exp_c[k]) || sat2 !== (k >= 2)) begin
            failures++;
            $display("FAIL sat_cnt[%0d]: got cnt=%0d sat=%0b expected cnt=%0d sat=%0b",
                     k, cnt2, sat2, exp_c[k], (k >= 2));
         end
      end
   endtask

   task automatic test_midstream_load();
      do_load(8'b101, 4'd3, 1'b1);
      drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1);
      // stale history 1,1 plus a 0 would match 110 if it survived the load
      do_load(8'b110, 4'd3, 1'b1);
      out_log = '0;
      drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0);
      settle();
      checks++;
      if (out_log[3:0] !== 4'b0001) begin
         failures++;
         $display("FAIL midload_pos: got %b expected 0001", out_log[3:0]);
      end
      checks++;
      if (cnt1 !== 8'd1) begin
         failures++;
         $display("FAIL midload_cnt: got %0d expected 1", cnt1);
      end
   endtask

   task automatic test_midstream_reset();
      do_load(8'b101, 4'd3, 1'b1);
      drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
      drive_bit(1'b1); drive_bit(1'b0);
      do_reset(1);
      out_log = '0;
      drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
      settle();
      checks++;
      if (out_log !== 32'd0 || cnt1 !== 8'd0) begin
         failures++;
         $display("FAIL midrst_idle: got log=%0h cnt=%0d expected 0 0", out_log, cnt1);
      end
      do_load(8'b101, 4'd3, 1'b1);
      out_log = '0;
      drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
      settle();
      checks++;
      if (out_log[2:0] !== 3'b001 || cnt1 !== 8'd1) begin
         failures++;
         $display("FAIL midrst_reload: got log=%b cnt=%0d expected 001 1", out_log[2:0], cnt1);
      end
   endtask

   task automatic test_clamp();
      logic [7:0] p;
      p = 8'b10110011;
      do_load(p, 4'd15, 1'b1);
      out_log = '0;
      for (int i = 7; i >= 0; i--) drive_bit(p[i]);
      settle();
      checks++;
      if (out_log[7:0] !== 8'b00000001 || cnt1 !== 8'd1) begin
         failures++;
         $display("FAIL clamp: got log=%b cnt=%0d expected 00000001 1", out_log[7:0], cnt1);
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      clr = 1'b0; cfg_load = 1'b0; cfg_pat = '0; cfg_len = '0;
      cfg_overlap = 1'b0; en = 1'b0; w = 1'b0; out_log = '0;
      m_pat = '0; m_len = 0; m_ovl = 1'b1; m_since = 0;
      test_reset();
      test_overlap();
      test_non_overlap();
      test_len4();
      test_gaps();
      test_saturate();
      test_midstream_load();
      test_midstream_reset();
      test_clamp();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_left: got %0d entries expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
